button_bank: RTL and testbench
==============================

Name: button_bank

Overview:
- Parametrised multi-channel front end for the board's push buttons and switches in the debug unit.
- Per channel: input synchronisation, debounce, clean level, and one-cycle press and release pulses.
- Optional per-channel hold-to-repeat pulse train, used for address inc/dec and single-step.
- Replaces the per-button single-channel debouncers. Adds reset, release detection, auto-repeat and compile-time timing.

Parameters:
N, 5, number of independent channels
DB_CYCLES, 16, consecutive cycles synchronised input must differ from level before level toggles; must be >= 2
RPT_DELAY, 1000000, cycles from press to first repeat pulse; must be >= 1
RPT_PERIOD, 250000, cycles between subsequent repeat pulses; must be >= 1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
in  input  N  raw button/switch inputs, asynchronous to clk
rpt_en  input  N  per-channel auto-repeat enable, synchronous to clk
level  output  N  debounced level
press  output  N  one-cycle pulse on debounced rising edge
rel  output  N  one-cycle pulse on debounced falling edge
rpt  output  N  one-cycle auto-repeat pulse
fire  output  N  press | rpt, registered, same cycle as its source

Behaviour:
- Reset:
  - Async on rst high: all outputs 0.
  - Synchroniser flops 0, level 0, counters 0, repeat state IDLE.
  - Effective immediately; takes priority mid-operation.
- Synchroniser: 2 flops per channel (s1 <= in, s2 <= s1). All logic below uses s2 only.
- Debounce, per channel:
  - Counter width $clog2(DB_CYCLES).
  - s2 == level: counter cleared.
  - s2 != level and counter == DB_CYCLES-1: level toggles, counter cleared.
  - Otherwise, s2 != level: counter increments.
  - Latency: for input changing before edge 1 and held, level updates at edge DB_CYCLES+2.
  - Pulses shorter than DB_CYCLES cycles at s2 produce no level change.
- press/rel:
  - Registered, asserted on the same edge level changes.
  - Exactly one cycle high per level transition.
- Auto-repeat FSM, per channel. Timer width $clog2(max(RPT_DELAY,RPT_PERIOD)+1).
  - IDLE: on the edge level rises with rpt_en=1, go to HOLD with timer=0. Otherwise stay.
  - HOLD: timer increments each cycle. On the edge where timer == RPT_DELAY-1: pulse rpt, go to REPEAT, timer=0.
  - REPEAT: timer increments. On the edge where timer == RPT_PERIOD-1: pulse rpt, timer=0.
  - HOLD/REPEAT exit to IDLE, timer=0, no rpt that cycle, when either:
    - the edge level falls (rel takes priority over a coincident repeat tick), or
    - rpt_en is sampled 0.
  - Re-asserting rpt_en while held does not restart repeating; a new press is required.
- fire = press | rpt. press and rpt are never high in the same cycle.
- Channels fully independent: simultaneous events on different channels produce pulses in the same cycle.
- Input high through reset:
  - level starts 0, so a press is generated DB_CYCLES+2 edges after rst deasserts.
  - This applies to any channel held during reset.
- No combinational path from any input to any output.

Test Plan (N=2, DB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=3 unless stated):
- Clean press: in[0] 0->1 before edge 1, held; rpt_en=0 -> level[0]=1, press[0]=fire[0]=1 for one cycle at edge 6; no rpt; in[0] back to 0 -> rel[0] pulse 6 edges later, level[0]=0.
- Glitch: in[0] high 3 cycles, then low -> level, press, rel all stay 0. Same input held 4 cycles -> level rises, press pulses.
- Auto-repeat: rpt_en[0]=1, hold in[0] -> press at edge 6, rpt at edges 16, 19, 22, ...; fire pulses on all of these. Release -> rel after debounce; no rpt after the level-fall edge.
- Repeat disable: hold in[0] 50 cycles with rpt_en[0]=0 -> exactly one press, zero rpt. Drop rpt_en mid REPEAT -> no further rpt while still held.
- Independence: in[1:0] rise together -> press[1:0]=2'b11 in the same cycle. Channel 1 released while channel 0 keeps repeating -> channel 0 rpt cadence unaffected.
- Reset mid-operation: assert rst during REPEAT with in[0]=1 -> all outputs 0 asynchronously. Deassert rst with in[0] still 1 -> press[0] at the 6th edge after deassert, FSM restarts from HOLD.

Source files
------------

// File: rtl/button_bank.sv
// -----------------------------------------------------------------------------
// button_bank
//   Multi-channel front end for push buttons and switches. Each channel has a
//   two-flop synchroniser, a counter-based debouncer producing a clean level,
//   one-cycle press/release pulses, and an optional hold-to-repeat pulse train.
//   All outputs are registered. There is no combinational path from any input
//   to any output.
//
// Parameters
//   N          number of independent channels
//   DB_CYCLES  consecutive cycles the synchronised input must differ from the
//              level before the level toggles (>= 2)
//   RPT_DELAY  cycles from press to the first repeat pulse (>= 1)
//   RPT_PERIOD cycles between subsequent repeat pulses (>= 1)
//
// Ports
//   clk     system clock
//   rst     asynchronous, active-high reset
//   in      raw button/switch inputs, asynchronous to clk
//   rpt_en  per-channel auto-repeat enable, synchronous to clk
//   level   debounced level
//   press   one-cycle pulse on a debounced rising edge
//   rel     one-cycle pulse on a debounced falling edge
//   rpt     one-cycle auto-repeat pulse
//   fire    press | rpt, in the same cycle as its source
// -----------------------------------------------------------------------------
module button_bank #(
   parameter int N          = 5,
   parameter int DB_CYCLES  = 16,
   parameter int RPT_DELAY  = 1000000,
   parameter int RPT_PERIOD = 250000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] in,
   input  logic [N-1:0] rpt_en,
   output logic [N-1:0] level,
   output logic [N-1:0] press,
   output logic [N-1:0] rel,
   output logic [N-1:0] rpt,
   output logic [N-1:0] fire
);

   localparam int CW      = $clog2(DB_CYCLES);
   localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
   localparam int TW      = $clog2(RPT_MAX + 1);

   localparam logic [CW-1:0] DB_LAST     = CW'(DB_CYCLES - 1);
   localparam logic [TW-1:0] DELAY_LAST  = TW'(RPT_DELAY - 1);
   localparam logic [TW-1:0] PERIOD_LAST = TW'(RPT_PERIOD - 1);

   // Auto-repeat states
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HOLD   = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   for (genvar i = 0; i < N; i++) begin : g_ch
      logic [1:0]    sync;      // sync[0] = first stage, sync[1] = stable copy
      logic [CW-1:0] db_cnt;
      logic          lvl_q;
      logic          press_q;
      logic          rel_q;
      logic          rpt_q;
      logic          fire_q;
      logic [1:0]    state;
      logic [TW-1:0] timer;

      logic db_done;
      logic rise;
      logic fall;
      logic tick;
      logic leave;
      logic rpt_next;

      // The input has disagreed with the level long enough: toggle this edge.
      assign db_done = (sync[1] != lvl_q) && (db_cnt == DB_LAST);
      assign rise    = db_done && !lvl_q;
      assign fall    = db_done &&  lvl_q;

      assign tick = ((state == ST_HOLD)   && (timer == DELAY_LAST)) ||
                    ((state == ST_REPEAT) && (timer == PERIOD_LAST));

      // Leaving the repeat sequence suppresses a coincident tick, so no
      // repeat pulse can follow (or share a cycle with) the release.
      assign leave    = fall || !rpt_en[i];
      assign rpt_next = tick && !leave;

      // NOTE: every register here is updated with non-blocking assignments so
      // all channels and stages see pre-edge values, and the asynchronous
      // reset clears all state (no memories exist, so nothing is left out).
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync    <= '0;
            db_cnt  <= '0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            rpt_q   <= 1'b0;
            fire_q  <= 1'b0;
            state   <= ST_IDLE;
            timer   <= '0;
         end else begin
            sync <= {sync[0], in[i]};

            // Debounce
            if (sync[1] == lvl_q || db_done) begin
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + CW'(1);
            end
            if (db_done) begin
               lvl_q <= !lvl_q;
            end

            press_q <= rise;
            rel_q   <= fall;
            rpt_q   <= rpt_next;
            fire_q  <= rise | rpt_next;

            // Auto-repeat
            case (state)
               ST_IDLE: begin
                  timer <= '0;
                  if (rise && rpt_en[i]) begin
                     state <= ST_HOLD;
                  end
               end
               ST_HOLD: begin
                  if (leave) begin
                     state <= ST_IDLE;
                     timer <= '0;
                  end else if (tick) begin
                     state <= ST_REPEAT;
                     timer <= '0;
                  end else begin
                     timer <= timer + TW'(1);
                  end
               end
               ST_REPEAT: begin
                  if (leave) begin
                     state <= ST_IDLE;
                     timer <= '0;
                  end else if (tick) begin
                     timer <= '0;
                  end else begin
                     timer <= timer + TW'(1);
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  timer <= '0;
               end
            endcase
         end
      end

      assign level[i] = lvl_q;
      assign press[i] = press_q;
      assign rel[i]   = rel_q;
      assign rpt[i]   = rpt_q;
      assign fire[i]  = fire_q;
   end

endmodule

// File: tb/tb_button_bank.sv
// -----------------------------------------------------------------------------
// tb_button_bank
//   Self-checking bench for button_bank (N=2, DB_CYCLES=4, RPT_DELAY=10,
//   RPT_PERIOD=3). A behavioural model predicts every output each cycle:
//   debounce as "input differed from level for DB_CYCLES consecutive samples",
//   repeat as "age since press reaches RPT_DELAY, then every RPT_PERIOD".
//   Directed scenarios additionally check absolute event edge numbers.
// -----------------------------------------------------------------------------
module tb_button_bank;

   localparam int NCH = 2;
   localparam int DB  = 4;
   localparam int DLY = 10;
   localparam int PER = 3;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [NCH-1:0] in_b = '0;
   logic [NCH-1:0] en_b = '0;
   logic [NCH-1:0] level_d, press_d, rel_d, rpt_d, fire_d;

   button_bank #(
      .N(NCH), .DB_CYCLES(DB), .RPT_DELAY(DLY), .RPT_PERIOD(PER)
   ) dut (
      .clk(clk), .rst(rst), .in(in_b), .rpt_en(en_b),
      .level(level_d), .press(press_d), .rel(rel_d), .rpt(rpt_d), .fire(fire_d)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
   endtask

   // ---------------- reference model ----------------
   logic [NCH-1:0] m_s1, m_s2, m_lvl, e_press, e_rel, e_rpt;
   int             m_run   [NCH];
   bit             m_armed [NCH];
   int             m_age   [NCH];

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_lvl = '0;
      e_press = '0; e_rel = '0; e_rpt = '0;
      for (int c = 0; c < NCH; c++) begin
         m_run[c] = 0; m_armed[c] = 0; m_age[c] = 0;
      end
   endtask

   task automatic model_step();
      bit rise, fall;
      for (int c = 0; c < NCH; c++) begin
         rise = 0;
         fall = 0;
         e_rpt[c] = 1'b0;
         if (m_s2[c] != m_lvl[c]) begin
            m_run[c]++;
            if (m_run[c] == DB) begin
               m_run[c] = 0;
               rise = !m_lvl[c];
               fall = m_lvl[c];
               m_lvl[c] = !m_lvl[c];
            end
         end else begin
            m_run[c] = 0;
         end
         if (m_armed[c]) begin
            if (fall || !en_b[c]) m_armed[c] = 0;
            else begin
               m_age[c]++;
               if (m_age[c] >= DLY && (m_age[c] - DLY) % PER == 0) e_rpt[c] = 1'b1;
            end
         end
         if (rise) begin
            m_armed[c] = en_b[c];
            m_age[c]   = 0;
         end
         e_press[c] = rise;
         e_rel[c]   = fall;
         m_s2[c] = m_s1[c];
         m_s1[c] = in_b[c];
      end
   endtask

   // ---------------- event logs (channel 0 unless noted) ----------------
   int edge_n;
   int p0[$];
   int l0[$];
   int r0[$];
   int both[$];

   task automatic mark();
      edge_n = 0;
      p0.delete(); l0.delete(); r0.delete(); both.delete();
   endtask

   // Drive inputs at the falling edge, step the model at the rising edge,
   // compare at the next falling edge.
   task automatic cycle(input logic [NCH-1:0] in_v, input logic [NCH-1:0] en_v);
      in_b = in_v;
      en_b = en_v;
      @(posedge clk);
      model_step();
      edge_n++;
      @(negedge clk);
      check("level", level_d, m_lvl);
      check("press", press_d, e_press);
      check("rel",   rel_d,   e_rel);
      check("rpt",   rpt_d,   e_rpt);
      check("fire",  fire_d,  e_press | e_rpt);
      if (press_d[0])       p0.push_back(edge_n);
      if (rel_d[0])         l0.push_back(edge_n);
      if (rpt_d[0])         r0.push_back(edge_n);
      if (press_d == 2'b11) both.push_back(edge_n);
   endtask

   task automatic run(input int n, input logic [NCH-1:0] in_v, input logic [NCH-1:0] en_v);
      for (int k = 0; k < n; k++) cycle(in_v, en_v);
   endtask

   // Asynchronous reset away from any clock edge; outputs must clear at once.
   task automatic do_reset(input logic [NCH-1:0] in_v, input logic [NCH-1:0] en_v);
      in_b = in_v;
      en_b = en_v;
      #2 rst = 1'b1;
      #1;
      check("rst_level", level_d, 0);
      check("rst_press", press_d, 0);
      check("rst_rel",   rel_d,   0);
      check("rst_rpt",   rpt_d,   0);
      check("rst_fire",  fire_d,  0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      mark();
   endtask

   initial begin
      logic [NCH-1:0] rin;
      logic [NCH-1:0] ren;
      int             hold_left [NCH];

      model_reset();

      // Clean press and release, no repeat
      do_reset(2'b00, 2'b00);
      run(12, 2'b01, 2'b00);
      check("clean_press_cnt", p0.size(), 1);
      check("clean_press_edge", p0[0], 6);
      check("clean_no_rpt", r0.size(), 0);
      mark();
      run(12, 2'b00, 2'b00);
      check("clean_rel_edge", l0[0], 6);

      // Glitch of 3 cycles is rejected, 4 cycles is accepted
      do_reset(2'b00, 2'b00);
      run(3, 2'b01, 2'b00);
      run(12, 2'b00, 2'b00);
      check("glitch_press", p0.size(), 0);
      check("glitch_rel", l0.size(), 0);
      mark();
      run(4, 2'b01, 2'b00);
      run(12, 2'b00, 2'b00);
      check("pulse4_press", p0.size(), 1);
      check("pulse4_rel", l0.size(), 1);

      // Auto-repeat cadence, then release
      do_reset(2'b00, 2'b01);
      run(30, 2'b01, 2'b01);
      check("rpt_press_edge", p0[0], 6);
      check("rpt_count", r0.size(), 5);
      check("rpt_first", r0[0], 16);
      check("rpt_second", r0[1], 19);
      check("rpt_last", r0[4], 28);
      mark();
      run(15, 2'b00, 2'b01);
      check("rel_after_rpt", l0[0], 6);
      check("rpt_before_fall", r0.size(), 2);

      // Repeat disabled while held; re-enable does not restart
      do_reset(2'b00, 2'b00);
      run(50, 2'b01, 2'b00);
      check("norpt_press", p0.size(), 1);
      check("norpt_rpt", r0.size(), 0);
      run(20, 2'b01, 2'b01);
      check("reenable_rpt", r0.size(), 0);

      // Drop rpt_en in REPEAT
      do_reset(2'b00, 2'b01);
      run(20, 2'b01, 2'b01);
      check("drop_pre_rpt", r0.size(), 2);
      mark();
      run(20, 2'b01, 2'b00);
      run(20, 2'b01, 2'b01);
      check("drop_post_rpt", r0.size(), 0);

      // Independence: simultaneous press, ch1 release while ch0 repeats
      do_reset(2'b00, 2'b01);
      run(20, 2'b11, 2'b01);
      check("both_press_edge", both[0], 6);
      run(20, 2'b01, 2'b01);
      check("indep_rpt_count", r0.size(), 9);
      check("indep_rpt_last", r0[8], 40);

      // Reset in REPEAT with input held through reset
      do_reset(2'b00, 2'b01);
      run(20, 2'b01, 2'b01);
      do_reset(2'b01, 2'b01);
      run(20, 2'b01, 2'b01);
      check("rst_held_press", p0[0], 6);
      check("rst_held_rpt", r0[0], 16);

      // Randomised phase
      rin = '0;
      ren = '0;
      for (int c = 0; c < NCH; c++) hold_left[c] = 0;
      do_reset(rin, ren);
      for (int k = 0; k < 4000; k++) begin
         for (int c = 0; c < NCH; c++) begin
            if (hold_left[c] == 0) begin
               rin[c] = ~rin[c];
               hold_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 45))
                                                         : int'($urandom_range(1, 8));
            end else begin
               hold_left[c]--;
            end
         end
         if ($urandom_range(0, 39) == 0) ren[$urandom_range(0, NCH-1)] ^= 1'b1;
         if ($urandom_range(0, 999) == 0) do_reset(rin, ren);
         cycle(rin, ren);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
